// File: rtl/banana_tracker.sv
`default_nettype none
// ============================================================================
// Module   : banana_tracker
// Purpose  : Per-frame collision check of the DK sprite against five fixed
//            world-space bananas. One banana is evaluated per clock after
//            frame_start. Collected bananas are cleared, counted and pulsed.
// Options  : BANANA_MARGIN_EN - grows every banana hit box by MARGIN pixels
//            on all four sides.
// Revision : 1.0 - initial release
// ============================================================================
module banana_tracker #(
    parameter int SPRITE_SIZE = 32,
    parameter int MARGIN      = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        restart,
    input  logic [15:0] outX,
    input  logic [9:0]  DK_X,
    input  logic [9:0]  DK_Y,
    input  logic [7:0]  W,
    input  logic [7:0]  H,
    output logic [4:0]  bananas,
    output logic [2:0]  banana_count,
    output logic        collect_pulse,
    output logic        busy,
    output logic        all_collected
);

`ifdef BANANA_MARGIN_EN
    localparam logic c_margin_en = 1'b1;
`else
    localparam logic c_margin_en = 1'b0;
`endif

    // All collision arithmetic is 17 bits wide so outX + DK_X + W cannot wrap.
    localparam logic [16:0] c_size   = 17'(SPRITE_SIZE);
    localparam logic [16:0] c_margin = c_margin_en ? 17'(MARGIN) : 17'd0;
    localparam logic [16:0] c_lo_off = c_size + c_margin;
    localparam logic [2:0]  c_last   = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [15:0] r_outx;
    logic [9:0]  r_dkx;
    logic [9:0]  r_dky;
    logic [7:0]  r_w;
    logic [7:0]  r_h;

    logic        w_clear;
    logic [4:0]  w_sel;
    logic [16:0] w_bx;
    logic [16:0] w_by;
    logic [16:0] w_x_lo;
    logic [16:0] w_x_hi;
    logic [16:0] w_y_lo;
    logic [16:0] w_y_hi;
    logic [16:0] w_dk_left;
    logic [16:0] w_dk_right;
    logic [16:0] w_dk_top;
    logic [16:0] w_dk_bottom;
    logic        w_hit;

    // Reset and restart behave identically and override everything else.
    assign w_clear = Reset | restart;

    // Banana table: world x of left edge, world y of bottom edge.
    always_comb begin
        w_bx = 17'd0;
        w_by = 17'd0;
        case (r_idx)
            3'd0:    begin w_bx = 17'd943;  w_by = 17'd255; end
            3'd1:    begin w_bx = 17'd1335; w_by = 17'd270; end
            3'd2:    begin w_bx = 17'd1500; w_by = 17'd270; end
            3'd3:    begin w_bx = 17'd2099; w_by = 17'd286; end
            3'd4:    begin w_bx = 17'd2562; w_by = 17'd336; end
            default: begin w_bx = 17'd0;    w_by = 17'd0;   end
        endcase
    end

    // Banana box, lower bounds clamped at zero instead of underflowing.
    assign w_x_lo = (w_bx >= c_margin) ? (w_bx - c_margin) : 17'd0;
    assign w_x_hi = w_bx + c_size + c_margin;
    assign w_y_lo = (w_by >= c_lo_off) ? (w_by - c_lo_off) : 17'd0;
    assign w_y_hi = w_by + c_margin;

    // DK box in world coordinates, built from the snapshot taken at frame_start.
    assign w_dk_left   = {1'b0, r_outx} + {7'd0, r_dkx};
    assign w_dk_right  = w_dk_left + {9'd0, r_w};
    assign w_dk_top    = {7'd0, r_dky};
    assign w_dk_bottom = w_dk_top + {9'd0, r_h};

    assign w_hit = (w_dk_left < w_x_hi) && (w_dk_right > w_x_lo) &&
                   (w_dk_top < w_y_hi) && (w_dk_bottom > w_y_lo);

    assign w_sel = 5'b00001 << r_idx;

    // State register.
    always_ff @(posedge Clk) begin
        if (w_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one pass of five checks, one DONE cycle, back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_next = CHECK;
            CHECK:   if (r_idx == c_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Snapshot capture, banana index walk and collection bookkeeping.
    always_ff @(posedge Clk) begin
        if (w_clear) begin
            bananas       <= 5'b11111;
            banana_count  <= 3'd0;
            collect_pulse <= 1'b0;
            r_idx         <= 3'd0;
            r_outx        <= 16'd0;
            r_dkx         <= 10'd0;
            r_dky         <= 10'd0;
            r_w           <= 8'd0;
            r_h           <= 8'd0;
        end else begin
            collect_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_outx <= outX;
                        r_dkx  <= DK_X;
                        r_dky  <= DK_Y;
                        r_w    <= W;
                        r_h    <= H;
                        r_idx  <= 3'd0;
                    end
                end
                CHECK: begin
                    // A hit on an already-cleared banana changes nothing.
                    if (w_hit && ((bananas & w_sel) != 5'd0)) begin
                        bananas       <= bananas & ~w_sel;
                        banana_count  <= banana_count + 3'd1;
                        collect_pulse <= 1'b1;
                    end
                    if (r_idx != c_last) begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (r_state != IDLE);
    assign all_collected = (bananas == 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_banana_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_banana_tracker
// Purpose  : Self-checking bench for banana_tracker. A cycle-count based
//            model predicts every output each cycle; directed frames pin the
//            model with hand-computed values, then random frames follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banana_tracker;

    localparam int S = 32;
    localparam int M = 8;

`ifdef BANANA_MARGIN_EN
    localparam int MM = M;
`else
    localparam int MM = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] outX = 16'd0;
    logic [9:0]  DK_X = 10'd0;
    logic [9:0]  DK_Y = 10'd0;
    logic [7:0]  W = 8'd0;
    logic [7:0]  H = 8'd0;
    logic [4:0]  bananas;
    logic [2:0]  banana_count;
    logic        collect_pulse;
    logic        busy;
    logic        all_collected;

    banana_tracker #(.SPRITE_SIZE(S), .MARGIN(M)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .restart(restart),
        .outX(outX), .DK_X(DK_X), .DK_Y(DK_Y), .W(W), .H(H),
        .bananas(bananas), .banana_count(banana_count),
        .collect_pulse(collect_pulse), .busy(busy), .all_collected(all_collected)
    );

    always #5 Clk = ~Clk;

    int bx[5] = '{943, 1335, 1500, 2099, 2562};
    int by[5] = '{255, 270, 270, 286, 336};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: bananas present, count, pulse, cycles since accepted frame_start.
    bit [4:0] m_ban;
    int       m_cnt;
    bit       m_pulse;
    int       m_phase;
    bit       m_hits[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(int i, int ox, int dx, int dy, int w, int h);
        int dk, xlo, xhi, ylo, yhi;
        dk  = ox + dx;
        xlo = bx[i] - MM;      if (xlo < 0) xlo = 0;
        xhi = bx[i] + S + MM;
        ylo = by[i] - S - MM;  if (ylo < 0) ylo = 0;
        yhi = by[i] + MM;
        return (dk < xhi) && (dk + w > xlo) && (dy < yhi) && (dy + h > ylo);
    endfunction

    // Model: advance on each rising edge from the inputs present at that edge.
    always @(posedge Clk) begin
        if (Reset || restart) begin
            m_ban = 5'b11111; m_cnt = 0; m_pulse = 0; m_phase = 0;
        end else begin
            m_pulse = 0;
            if (m_phase == 0) begin
                if (frame_start) begin
                    for (int i = 0; i < 5; i++)
                        m_hits[i] = model_hit(i, int'(outX), int'(DK_X), int'(DK_Y), int'(W), int'(H));
                    m_phase = 1;
                end
            end else begin
                if (m_phase <= 5 && m_hits[m_phase-1] && m_ban[m_phase-1]) begin
                    m_ban[m_phase-1] = 1'b0;
                    m_cnt++;
                    m_pulse = 1;
                end
                m_phase = (m_phase == 6) ? 0 : m_phase + 1;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("bananas", 32'(bananas), 32'(m_ban));
            chk("banana_count", 32'(banana_count), 32'(m_cnt));
            chk("collect_pulse", 32'(collect_pulse), 32'(m_pulse));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("all_collected", 32'(all_collected), 32'(m_ban == 5'd0));
        end
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic do_restart();
        restart = 1'b1; tick(); restart = 1'b0;
    endtask

    // Issue one frame; pmask bit k set when collect_pulse is seen in cycle k.
    task automatic run_frame(input int ox, input int dx, input int dy, input int w, input int h,
                             input int refire, output int pmask, output int nbusy);
        outX = 16'(ox); DK_X = 10'(dx); DK_Y = 10'(dy); W = 8'(w); H = 8'(h);
        frame_start = 1'b1;
        pmask = 0; nbusy = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            frame_start = (k == refire);
            if (collect_pulse) pmask |= (1 << k);
            if (busy) nbusy++;
        end
        frame_start = 1'b0;
    endtask

    int pm, nb, t;

    initial begin
        tick(); tick();
        Reset = 1'b0;
        chk_en = 1'b1;
        chk("reset bananas", 32'(bananas), 32'h1f);
        chk("reset count", 32'(banana_count), 0);
        chk("reset busy", 32'(busy), 0);

        // Frame far from every banana.
        run_frame(0, 100, 300, 40, 50, 0, pm, nb);
        chk("miss busy cycles", nb, 6);
        chk("miss pulses", pm, 0);
        chk("miss bananas", 32'(bananas), 32'h1f);

        // dkwx=940 overlaps banana 0; pulse in cycle 2.
        run_frame(860, 80, 200, 40, 50, 0, pm, nb);
        chk("b0 pulse cycle", pm, 32'h4);
        chk("b0 bananas", 32'(bananas), 32'h1e);
        chk("b0 count", 32'(banana_count), 1);
        chk("b0 model pin", 32'(m_ban), 32'h1e);
        run_frame(860, 80, 200, 40, 50, 0, pm, nb);
        chk("b0 repeat pulses", pm, 0);
        chk("b0 repeat bananas", 32'(bananas), 32'h1e);

        // Wide DK covers bananas 1 and 2: pulses in cycles 3 and 4.
        run_frame(1300, 40, 240, 200, 30, 0, pm, nb);
        chk("b12 pulses", pm, 32'h18);
        chk("b12 bananas", 32'(bananas), 32'h18);
        chk("b12 count", 32'(banana_count), 3);

        // frame_start while busy is ignored.
        run_frame(0, 100, 300, 40, 50, 3, pm, nb);
        chk("refire busy cycles", nb, 6);

        // Restart in CHECK cycle 3 of a hitting frame.
        do_restart();
        outX = 16'd1300; DK_X = 10'd40; DK_Y = 10'd240; W = 8'd200; H = 8'd30;
        frame_start = 1'b1; tick();
        frame_start = 1'b0; tick();
        frame_start = 1'b1; tick();
        frame_start = 1'b0; restart = 1'b1;
        chk("pre-restart pulse", 32'(collect_pulse), 1);
        tick();
        restart = 1'b0;
        chk("restart bananas", 32'(bananas), 32'h1f);
        chk("restart count", 32'(banana_count), 0);
        chk("restart busy", 32'(busy), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("post-restart busy", 32'(busy), 0);
        end

        // Collect all five, one per frame.
        for (int i = 0; i < 5; i++) begin
            run_frame(bx[i], 0, by[i] - 10, 10, 5, 0, pm, nb);
            chk("single pulse", pm, 1 << (i + 2));
        end
        chk("all count", 32'(banana_count), 5);
        chk("all_collected", 32'(all_collected), 1);

        // Large offsets must not wrap into a hit.
        do_restart();
        run_frame(65535, 1023, 200, 255, 50, 0, pm, nb);
        chk("overflow 1023", pm, 0);
        run_frame(65535, 960, 200, 40, 50, 0, pm, nb);
        chk("overflow 960", pm, 0);
        chk("overflow bananas", 32'(bananas), 32'h1f);

        // Just outside banana 0 unless the margin box is enabled.
        run_frame(900, 80, 200, 10, 30, 0, pm, nb);
`ifdef BANANA_MARGIN_EN
        chk("margin hit", pm, 32'h4);
`else
        chk("margin miss", pm, 0);
`endif

        // Random traffic biased toward the banana boxes.
        do_restart();
        for (int n = 0; n < 1500; n++) begin
            int r, k;
            r = int'($urandom_range(0, 199));
            Reset = (r < 2);
            restart = (r >= 2 && r < 6);
            frame_start = ($urandom_range(0, 3) == 0);
            k = int'($urandom_range(0, 4));
            DK_X = 10'($urandom_range(0, 1023));
            t = bx[k] + int'($urandom_range(0, 80)) - 40 - int'(DK_X);
            if (t < 0 || $urandom_range(0, 7) == 0) t = int'($urandom_range(0, 65535));
            outX = 16'(t);
            W = 8'($urandom_range(0, 255));
            t = by[k] - int'($urandom_range(0, 80));
            if (t < 0) t = 0;
            DK_Y = 10'(t);
            H = 8'($urandom_range(0, 255));
            tick();
        end
        Reset = 1'b0; restart = 1'b0; frame_start = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
